serial_addsub: RTL

Multi-cycle, parametrised adder/subtractor built around a BITS_PER_CYCLE-wide ripple-carry slice. The slice is reused every cycle to process the operands LSB-first. It is the sequential successor to the combinational full-adder/ripple-carry datapath and trades latency for area in the ALU. A start/busy/done handshake sequences each operation. The block registers the sum, the carry-out and the signed-overflow flag.

---
 rtl/serial_addsub.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
`default_nettype none
// =====================================================================
// serial_addsub : multi-cycle LSB-first adder/subtractor that reuses a
//                 BITS_PER_CYCLE-wide ripple-carry slice every cycle
// Rev 1.0
// =====================================================================
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]          a_sr;
  logic [WIDTH-1:0]          b_sr;
  logic                      carry;
  logic [CNT_W-1:0]          cnt;
  logic                      last_step;
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout;
  logic                      slice_msb_cin;
  logic [WIDTH-1:0]          psum_next;

  assign last_step = (cnt == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Ripple slice; in the final step its top bit is the word MSB, so the
  // carry entering that bit is the one needed for signed overflow.
  always_comb begin : slice
    logic c;
    c             = carry;
    slice_msb_cin = carry;
    slice_sum     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i == BITS_PER_CYCLE - 1) slice_msb_cin = c;
      slice_sum[i] = a_sr[i] ^ b_sr[i] ^ c;
      c            = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    slice_cout = c;
  end

  generate
    if (BITS_PER_CYCLE < WIDTH) begin : g_multi_step
      logic [WIDTH-BITS_PER_CYCLE-1:0] psum;

      assign psum_next = {slice_sum, psum};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          psum <= '0;
        end else if (state == S_RUN) begin
          psum <= psum_next[WIDTH-1:BITS_PER_CYCLE];
        end
      end
    end else begin : g_single_step
      assign psum_next = slice_sum;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= mode ? ~b : b;
            carry <= mode | cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> BITS_PER_CYCLE;
          b_sr  <= b_sr >> BITS_PER_CYCLE;
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            sum  <= psum_next;
            cout <= slice_cout;
            ovf  <= slice_msb_cin ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
